// File: rtl/rambam_pkg.sv
// Constants for the RAMBAM inverse S-box: ring modulus P*Q, the inverse affine map and
// the Frobenius power matrices. All of them are elaborated from P, Q and D.
package rambam_pkg;
  localparam int D = 8;
  localparam int W = 8 + D;
  localparam logic [8:0] P = 9'h11B;
  localparam logic [D:0] Q = (D+1)'(9'h1F5);

  typedef logic [W-1:0]          elem_t;
  typedef logic [2*W-2:0]        prod_t;
  typedef logic [W-1:0][W-1:0]   mat_t;
  typedef enum logic [3:0] {IDLE, AFF, S1, S2, S3, S4, S5, S6, S7, DONE} state_t;

  function automatic logic [W:0] pq_calc();
    logic [W:0] acc;
    acc = '0;
    for (int i = 0; i <= D; i++)
      if (Q[i]) acc = acc ^ ((W+1)'(P) << i);
    return acc;
  endfunction

  localparam logic [W:0] PQ = pq_calc();

  function automatic elem_t mulx_pq(input elem_t v);
    logic [W:0] s;
    s = {v, 1'b0};
    if (s[W]) s = s ^ PQ;
    return s[W-1:0];
  endfunction

  function automatic elem_t xpow_pq(input int n);
    elem_t v;
    v = elem_t'(1);
    for (int i = 0; i < n; i++) v = mulx_pq(v);
    return v;
  endfunction

  // Column j of a Frobenius matrix is the image of X^j, i.e. X^(e*j) mod PQ.
  function automatic mat_t pow_mat(input int e);
    mat_t m;
    for (int j = 0; j < W; j++) m[j] = xpow_pq(e * j);
    return m;
  endfunction

  function automatic logic [7:0] gf_xpow(input int n);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < n; i++)
      v = v[7] ? ((v << 1) ^ P[7:0]) : (v << 1);
    return v;
  endfunction

  function automatic logic [7:0] inv_lin(input logic [7:0] y);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = y[(i+2)%8] ^ y[(i+5)%8] ^ y[(i+7)%8];
    return b;
  endfunction

  // Linear part of the inverse affine, applied to X^j mod P so any redundant input works.
  function automatic mat_t winv_calc();
    mat_t m;
    for (int j = 0; j < W; j++) m[j] = elem_t'(inv_lin(gf_xpow(j)));
    return m;
  endfunction

  localparam mat_t  pow2_mat  = pow_mat(2);
  localparam mat_t  pow4_mat  = pow_mat(4);
  localparam mat_t  pow16_mat = pow_mat(16);
  localparam mat_t  Winv      = winv_calc();
  localparam elem_t winv      = elem_t'(inv_lin(8'h63));

  function automatic elem_t mat_apply(input mat_t m, input elem_t x);
    elem_t y;
    y = '0;
    for (int j = 0; j < W; j++)
      if (x[j]) y = y ^ m[j];
    return y;
  endfunction

  function automatic prod_t clmul_w(input elem_t a, input elem_t b);
    prod_t acc;
    acc = '0;
    for (int i = 0; i < W; i++)
      if (b[i]) acc = acc ^ (prod_t'(a) << i);
    return acc;
  endfunction

  function automatic elem_t mod_pq(input prod_t v);
    prod_t t;
    t = v;
    for (int i = 2*W-2; i >= W; i--)
      if (t[i]) t = t ^ (prod_t'(PQ) << (i - W));
    return t[W-1:0];
  endfunction

  // r*P has degree below W, so adding it needs no reduction and keeps the value mod P.
  function automatic elem_t clmul_p(input logic [D-1:0] rv);
    elem_t acc;
    acc = '0;
    for (int i = 0; i < D; i++)
      if (rv[i]) acc = acc ^ (elem_t'(P) << i);
    return acc;
  endfunction
endpackage

// File: rtl/rambam_mulmod.sv
// Combinational carry-less multiply of two ring elements, reduced mod P*Q.
module rambam_mulmod
  import rambam_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);
  assign p = mod_pq(clmul_w(a, b));
endmodule

// File: rtl/rambam_inv_sbox_seq.sv
// Sequential masked RAMBAM inverse S-box: inverse affine, then x^254 by an addition chain,
// one refreshed ring step per cycle. Define RAMBAM_OUT_REFRESH_EN to add the r_out refresh.
module rambam_inv_sbox_seq
  import rambam_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     ciphertext,
  input  logic [7*D-1:0]   r,
`ifdef RAMBAM_OUT_REFRESH_EN
  input  logic [D-1:0]     r_out,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out
);
  state_t         state;
  logic [W-1:0]   x_q, t1, t2, t3, t12, t14, t15, t240;
  logic [7*D-1:0] r_q;
  logic [2:0]     ridx;
  logic [W-1:0]   rf, ma, mb, mp, fin;
  logic           accept;

  assign in_ready = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  // Refresh word index and the shared multiplier's operands follow the step state.
  always_comb begin
    ridx = 3'd0;
    ma   = '0;
    mb   = '0;
    case (state)
      S1: ridx = 3'd0;
      S2: begin ridx = 3'd1; ma = t2;   mb = t1;  end
      S3: ridx = 3'd2;
      S4: begin ridx = 3'd3; ma = t12;  mb = t2;  end
      S5: begin ridx = 3'd4; ma = t12;  mb = t3;  end
      S6: ridx = 3'd5;
      S7: begin ridx = 3'd6; ma = t240; mb = t14; end
      default: ;
    endcase
  end

  assign rf = clmul_p(r_q[ridx*D +: D]);

  rambam_mulmod u_mul (.a(ma), .b(mb), .p(mp));

`ifdef RAMBAM_OUT_REFRESH_EN
  logic [D-1:0] r_out_q;
  assign fin = mp ^ rf ^ clmul_p(r_out_q);
`else
  assign fin = mp ^ rf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_q       <= '0;
      r_q       <= '0;
      t1        <= '0;
      t2        <= '0;
      t3        <= '0;
      t12       <= '0;
      t14       <= '0;
      t15       <= '0;
      t240      <= '0;
      out       <= '0;
      out_valid <= 1'b0;
`ifdef RAMBAM_OUT_REFRESH_EN
      r_out_q   <= '0;
`endif
    end else begin
      if (accept) begin
        x_q <= ciphertext;
        r_q <= r;
`ifdef RAMBAM_OUT_REFRESH_EN
        r_out_q <= r_out;
`endif
      end
      case (state)
        IDLE: if (in_valid) state <= AFF;
        AFF:  begin t1   <= mat_apply(Winv, x_q) ^ winv;          state <= S1; end
        S1:   begin t2   <= mat_apply(pow2_mat, t1) ^ rf;         state <= S2; end
        S2:   begin t3   <= mp ^ rf;                              state <= S3; end
        S3:   begin t12  <= mat_apply(pow4_mat, t3) ^ rf;         state <= S4; end
        S4:   begin t14  <= mp ^ rf;                              state <= S5; end
        S5:   begin t15  <= mp ^ rf;                              state <= S6; end
        S6:   begin t240 <= mat_apply(pow16_mat, t15) ^ rf;       state <= S7; end
        S7:   begin out  <= fin; out_valid <= 1'b1;               state <= DONE; end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= in_valid ? AFF : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
